onchip_mem_stream_reader: RTL
=============================

// Module: onchip_mem_stream_reader
// PURPOSE
//  Avalon-MM read master for one port of the 32-bit dual-port on-chip RAM (no waitrequest, fixed read latency).
//  Takes a (start address, length) command and fetches that many consecutive words.
//  Emits the words as an Avalon-ST packet with backpressure. Used by graphics/DMA paths that stream RAM contents out.
// PARAMETERS
//  ADDR_W        12  word-address width of the RAM port (depth 2**ADDR_W)
//  DATA_W        32  data width
//  READ_LATENCY  1   cycles from address/chipselect to valid mem_readdata (>=1)
//  FIFO_DEPTH    4   output skid FIFO entries (power of 2, >= READ_LATENCY+1)
// PORTS
//  clk             in   1         single clock for all logic
//  reset           in   1         asynchronous, active-high reset
//  cmd_valid       in   1         command request
//  cmd_ready       out  1         command accepted when cmd_valid&cmd_ready
//  cmd_addr        in   ADDR_W    start word address
//  cmd_len         in   ADDR_W+1  number of words, 0..2**ADDR_W
//  mem_address     out  ADDR_W    RAM word address
//  mem_chipselect  out  1         RAM read strobe (one read per cycle asserted)
//  mem_write       out  1         tied 0
//  mem_byteenable  out  DATA_W/8  tied all-ones
//  mem_clken       out  1         tied 1
//  mem_readdata    in   DATA_W    RAM read data, valid READ_LATENCY cycles after strobe
//  out_valid       out  1         stream beat valid
//  out_ready       in   1         sink ready; beat transfers on out_valid&out_ready
//  out_data        out  DATA_W    stream data
//  out_sop         out  1         first beat of the packet
//  out_eop         out  1         last beat of the packet
//  busy            out  1         high from command accept until done
//  done            out  1         one-cycle pulse when the command completes
// BEHAVIOUR
//  Reset values: cmd_ready=0, mem_chipselect=0, mem_address=0, out_valid=0, out_sop=0, out_eop=0,
//   out_data=0, busy=0, done=0. FIFO, latency pipe and counters are cleared. State=IDLE.
//  Reset mid-command aborts it: in-flight reads are discarded, no done pulse, no partial EOP.
//  FSM:
//   - IDLE: cmd_ready=1.
//     - Accept with cmd_len=0: done pulses the next cycle, no beats, stay IDLE.
//     - Accept with cmd_len>0: latch addr and remaining=cmd_len; busy=1 next cycle; go to ISSUE.
//   - ISSUE: cmd_ready=0.
//     - Each cycle with credit: mem_chipselect=1 at the current address; then addr<=addr+1 (wraps mod 2**ADDR_W)
//       and remaining<=remaining-1. Tag the read sop (first of the command) and eop (remaining==1).
//     - Issuing the last word moves the FSM to DRAIN.
//   - DRAIN: wait until the EOP beat transfers on the stream.
//     - Then: done=1 for one cycle, busy=0, go to IDLE. The next command may be accepted the following cycle.
//  Credit rule (registered counts): issue only if inflight+fifo_count < FIFO_DEPTH. No RAM data is ever dropped.
//   - inflight = strobes not yet returned.
//   - A same-cycle FIFO pop does not add credit that cycle.
//  Latency pipe:
//   - A READ_LATENCY-deep shift register carries {valid, sop, eop} alongside each strobe.
//   - At its tail, mem_readdata and the flags are pushed into the FIFO.
//  FIFO / stream:
//   - out_* are driven from the FIFO head.
//   - Pop on out_valid&out_ready. Simultaneous push and pop is allowed at any occupancy.
//   - out_data/sop/eop hold stable while out_valid&~out_ready.
//  Throughput: with READ_LATENCY=1, FIFO_DEPTH=4 and out_ready held at 1, one beat per cycle is sustained.
//  First-beat latency from cmd accept is READ_LATENCY+2 cycles.
//  A 1-word command asserts out_sop and out_eop on the same beat.
// TESTING
//  1. Accept cmd_addr=0x010, cmd_len=4 with RAM preloaded mem[i]=i, out_ready=1
//     -> beats 0x10,0x11,0x12,0x13 on consecutive cycles; sop on 0x10, eop on 0x13; one done pulse.
//  2. Accept cmd_addr=0xFFE, cmd_len=4 -> read addresses 0xFFE,0xFFF,0x000,0x001 (wrap); 4 beats in order.
//  3. cmd_len=16, out_ready toggled 1/0 every cycle
//     -> all 16 beats delivered in order, none lost or duplicated; inflight+fifo_count never exceeds 4.
//  4. cmd_len=0 -> cmd_ready handshake; done pulses the next cycle; out_valid stays 0; busy stays 0.
//  5. cmd_len=1 -> single beat with sop=eop=1. cmd_valid held high during busy -> second command accepted only after done.
//  6. Assert reset during a cmd_len=8 transfer after 3 beats
//     -> all outputs return to reset values immediately; no done; a new command then streams correctly from its start.

Source files
------------

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master that streams a (start, length) window of an on-chip RAM
// out as one Avalon-ST packet, with credit-based flow control into a skid FIFO.
module onchip_mem_stream_reader #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  // Handshakes (cmd_* and out_*): a transfer happens on any rising clk edge where
  // valid and ready are both high; the source holds its payload stable until then.
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ADDR_W:0]     cmd_len,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_sop,
  output logic                out_eop,
  output logic                busy,
  output logic                done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic                first_q, first_d;
  logic                done_q, done_d;
  logic                active_q;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;

  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_sop_q, pipe_eop_q;

  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_sop_q, fifo_eop_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;

  logic [CNT_W:0]      occupancy;
  logic                credit;
  logic                issue;
  logic                push;
  logic                pop;
  logic                accept;
  logic                issue_eop;

  // Credit uses registered counts only, so a pop frees its slot one cycle later.
  assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign credit    = occupancy < (CNT_W+1)'(FIFO_DEPTH);
  assign issue     = (state_q == S_ISSUE) && credit;
  assign issue_eop = (rem_q == (ADDR_W+1)'(1));
  assign push      = pipe_vld_q[READ_LATENCY-1];
  assign pop       = out_valid && out_ready;
  assign accept    = cmd_valid && cmd_ready;

  assign cmd_ready      = (state_q == S_IDLE) && active_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign mem_address    = addr_q;
  assign mem_chipselect = issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;

  assign out_valid = (fifo_cnt_q != '0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_sop   = out_valid && fifo_sop_q[rd_ptr_q];
  assign out_eop   = out_valid && fifo_eop_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    first_d = first_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
            first_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          first_d = 1'b0;
          if (issue_eop) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && out_eop) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, push})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      first_q    <= 1'b0;
      done_q     <= 1'b0;
      active_q   <= 1'b0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      first_q    <= first_d;
      done_q     <= done_d;
      active_q   <= 1'b1;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Tags travel beside each strobe so they meet mem_readdata at the tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld_q <= '0;
      pipe_sop_q <= '0;
      pipe_eop_q <= '0;
    end else begin
      pipe_vld_q[0] <= issue;
      pipe_sop_q[0] <= issue && first_q;
      pipe_eop_q[0] <= issue && issue_eop;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_sop_q[i] <= pipe_sop_q[i-1];
        pipe_eop_q[i] <= pipe_eop_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_sop_q <= '0;
      fifo_eop_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_readdata;
        fifo_sop_q[wr_ptr_q]  <= pipe_sop_q[READ_LATENCY-1];
        fifo_eop_q[wr_ptr_q]  <= pipe_eop_q[READ_LATENCY-1];
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

endmodule
